// File: rtl/reu_registers_if.sv
// C64 register bus and DMA-engine handshake for the REU register block.
interface reu_registers_if;
    logic [4:0]  a;
    logic [7:0]  d_d;
    logic [7:0]  d_q;
    logic        read_strobe;
    logic        write_strobe;
    logic        ff00_write;
    logic        dma_start;
    logic        dma_busy;
    logic        dma_step;
    logic        dma_done;
    logic        verify_err;
    logic [15:0] c64_addr;
    logic [23:0] reu_addr;
    logic [15:0] xfer_len;
    logic [1:0]  xfer_type;
    logic        irq;

    modport master (
        output a, d_d, read_strobe, write_strobe, ff00_write, dma_step, dma_done, verify_err,
        input  d_q, dma_start, dma_busy, c64_addr, reu_addr, xfer_len, xfer_type, irq
    );

    modport slave (
        input  a, d_d, read_strobe, write_strobe, ff00_write, dma_step, dma_done, verify_err,
        output d_q, dma_start, dma_busy, c64_addr, reu_addr, xfer_len, xfer_type, irq
    );
endinterface

// File: rtl/reu_registers.sv
// REU register file, transfer-launch FSM and DMA working/shadow registers.
// Define REU_16M_EN for a full 8-bit bank (16 MB); default is a 3-bit bank (512 KB).
module reu_registers (
    input  logic           clk,
    input  logic           reset,
    reu_registers_if.slave bus
);
`ifdef REU_16M_EN
    localparam logic [23:0] REU_MASK = 24'hFF_FFFF;
    localparam logic [7:0]  BANK_RD  = 8'h00;
`else
    localparam logic [23:0] REU_MASK = 24'h07_FFFF;
    localparam logic [7:0]  BANK_RD  = 8'hF8;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

    state_t      state, state_next;
    logic        start, start_next;
    logic [2:0]  st_bits;
    logic        cmd_exec, cmd_autoload, cmd_ff00_dis;
    logic [1:0]  cmd_type;
    logic [15:0] c64_work, c64_shadow, len_work, len_shadow;
    logic [23:0] reu_work, reu_shadow;
    logic [2:0]  mask, mask_eff;
    logic        fix_c64, fix_reu;
    logic [7:0]  rdata, rd_mux;
    logic [1:0]  st65_next;
    logic        st7_next;
    logic        busy, wr, step, done, cmd_wr;

    // Length counts down but parks at 1 so the last byte never underflows.
    function automatic logic [15:0] len_dec(input logic [15:0] v);
        return (v == 16'd1) ? v : v - 16'd1;
    endfunction

    assign busy   = (state == BUSY);
    assign wr     = bus.write_strobe && !busy;
    assign step   = bus.dma_step && busy;
    assign done   = bus.dma_done && busy;
    assign cmd_wr = wr && (bus.a == 5'd1);

    always_comb begin
        case (bus.a)
            5'd0:    rd_mux = {st_bits, 5'b10000};
            5'd1:    rd_mux = {cmd_exec, 1'b1, cmd_autoload, cmd_ff00_dis, 2'b11, cmd_type};
            5'd2:    rd_mux = c64_work[7:0];
            5'd3:    rd_mux = c64_work[15:8];
            5'd4:    rd_mux = reu_work[7:0];
            5'd5:    rd_mux = reu_work[15:8];
            5'd6:    rd_mux = reu_work[23:16] | BANK_RD;
            5'd7:    rd_mux = len_work[7:0];
            5'd8:    rd_mux = len_work[15:8];
            5'd9:    rd_mux = {mask, 5'h1F};
            5'd10:   rd_mux = {fix_c64, fix_reu, 6'h3F};
            default: rd_mux = 8'hFF;
        endcase
    end

    // Status read clears first, so a coincident dma_done still leaves its bit set.
    always_comb begin
        st65_next = st_bits[1:0];
        st7_next  = st_bits[2];
        mask_eff  = (wr && bus.a == 5'd9) ? bus.d_d[7:5] : mask;
        if (bus.read_strobe && bus.a == 5'd0) begin
            st65_next = 2'b00;
            st7_next  = 1'b0;
        end
        if (done) begin
            if (bus.verify_err) st65_next[0] = 1'b1;
            else                st65_next[1] = 1'b1;
        end
        if (mask_eff[2] && ((mask_eff[1] && st65_next[1]) || (mask_eff[0] && st65_next[0])))
            st7_next = 1'b1;
    end

    always_comb begin
        state_next = state;
        start_next = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_wr && bus.d_d[7]) begin
                    if (bus.d_d[4]) begin
                        state_next = BUSY;
                        start_next = 1'b1;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (bus.ff00_write) begin
                    state_next = BUSY;
                    start_next = 1'b1;
                end else if (cmd_wr && !bus.d_d[7]) begin
                    state_next = IDLE;
                end
            end
            BUSY:    if (bus.dma_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
        end else begin
            state <= state_next;
            start <= start_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_bits      <= 3'b000;
            cmd_exec     <= 1'b0;
            cmd_autoload <= 1'b0;
            cmd_ff00_dis <= 1'b1;
            cmd_type     <= 2'b00;
            c64_work     <= 16'h0000;
            c64_shadow   <= 16'h0000;
            reu_work     <= 24'h00_0000;
            reu_shadow   <= 24'h00_0000;
            len_work     <= 16'hFFFF;
            len_shadow   <= 16'hFFFF;
            mask         <= 3'b000;
            fix_c64      <= 1'b0;
            fix_reu      <= 1'b0;
            rdata        <= 8'hFF;
        end else begin
            st_bits <= {st7_next, st65_next};
            if (bus.read_strobe) rdata <= rd_mux;
            if (wr) begin
                case (bus.a)
                    5'd1: begin
                        cmd_exec     <= bus.d_d[7];
                        cmd_autoload <= bus.d_d[5];
                        cmd_ff00_dis <= bus.d_d[4];
                        cmd_type     <= bus.d_d[1:0];
                    end
                    5'd2: begin c64_work[7:0]   <= bus.d_d; c64_shadow[7:0]   <= bus.d_d; end
                    5'd3: begin c64_work[15:8]  <= bus.d_d; c64_shadow[15:8]  <= bus.d_d; end
                    5'd4: begin reu_work[7:0]   <= bus.d_d; reu_shadow[7:0]   <= bus.d_d; end
                    5'd5: begin reu_work[15:8]  <= bus.d_d; reu_shadow[15:8]  <= bus.d_d; end
                    5'd6: begin
                        reu_work[23:16]   <= bus.d_d & REU_MASK[23:16];
                        reu_shadow[23:16] <= bus.d_d & REU_MASK[23:16];
                    end
                    5'd7: begin len_work[7:0]   <= bus.d_d; len_shadow[7:0]   <= bus.d_d; end
                    5'd8: begin len_work[15:8]  <= bus.d_d; len_shadow[15:8]  <= bus.d_d; end
                    5'd9:  mask <= bus.d_d[7:5];
                    5'd10: begin fix_c64 <= bus.d_d[7]; fix_reu <= bus.d_d[6]; end
                    default: ;
                endcase
            end
            if (step) begin
                if (!fix_c64) c64_work <= c64_work + 16'd1;
                if (!fix_reu) reu_work <= (reu_work + 24'd1) & REU_MASK;
                len_work <= len_dec(len_work);
            end
            // Autoload reload overrides a coincident final step.
            if (done) begin
                cmd_exec <= 1'b0;
                if (cmd_autoload) begin
                    c64_work <= c64_shadow;
                    reu_work <= reu_shadow;
                    len_work <= len_shadow;
                end
            end
        end
    end

    assign bus.d_q       = rdata;
    assign bus.dma_start = start;
    assign bus.dma_busy  = busy;
    assign bus.c64_addr  = c64_work;
    assign bus.reu_addr  = reu_work;
    assign bus.xfer_len  = len_work;
    assign bus.xfer_type = cmd_type;
    assign bus.irq       = st_bits[2];
endmodule

// File: tb/tb_reu_registers.sv
// Bench for reu_registers: directed scenarios plus random traffic against a transaction-level model.
module tb_reu_registers;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reu_registers_if bus ();
    reu_registers dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef REU_16M_EN
    localparam int unsigned REU_SIZE = 32'h0100_0000;
`else
    localparam int unsigned REU_SIZE = 32'h0008_0000;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 waiting for $FF00, 2 transferring.
    int unsigned m_phase, m_status, m_cmd, m_mask, m_ctrl;
    int unsigned m_c64, m_reu, m_len, s_c64, s_reu, s_len, m_dq;
    bit          m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned put_byte(int unsigned v, int unsigned sh, int unsigned d);
        return (v & ~(32'hFF << sh)) | (d << sh);
    endfunction

    function automatic int unsigned model_read(int unsigned idx);
        case (idx)
            0:  return m_status;
            1:  return m_cmd | 32'h4C;
            2:  return m_c64 & 32'hFF;
            3:  return m_c64 >> 8;
            4:  return m_reu & 32'hFF;
            5:  return (m_reu >> 8) & 32'hFF;
            6:  return ((m_reu >> 16) | ~((REU_SIZE - 1) >> 16)) & 32'hFF;
            7:  return m_len & 32'hFF;
            8:  return m_len >> 8;
            9:  return m_mask | 32'h1F;
            10: return m_ctrl | 32'h3F;
            default: return 32'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_status = 32'h10; m_cmd = 32'h10; m_mask = 0; m_ctrl = 0;
        m_c64 = 0; m_reu = 0; m_len = 32'hFFFF; s_c64 = 0; s_reu = 0; s_len = 32'hFFFF;
        m_dq = 32'hFF; m_start = 0;
    endtask

    task automatic model_write(int unsigned idx, int unsigned d);
        if (m_phase == 2) return;
        case (idx)
            1: begin
                m_cmd = d & 32'hB3;
                if (m_phase == 0 && (d & 32'h80) != 0) begin
                    if ((d & 32'h10) != 0) begin m_phase = 2; m_start = 1; end
                    else m_phase = 1;
                end else if (m_phase == 1 && (d & 32'h80) == 0) m_phase = 0;
            end
            2, 3: begin
                m_c64 = put_byte(m_c64, (idx - 2) * 8, d);
                s_c64 = put_byte(s_c64, (idx - 2) * 8, d);
            end
            4, 5, 6: begin
                m_reu = put_byte(m_reu, (idx - 4) * 8, d) & (REU_SIZE - 1);
                s_reu = put_byte(s_reu, (idx - 4) * 8, d) & (REU_SIZE - 1);
            end
            7, 8: begin
                m_len = put_byte(m_len, (idx - 7) * 8, d);
                s_len = put_byte(s_len, (idx - 7) * 8, d);
            end
            9:  m_mask = d & 32'hE0;
            10: m_ctrl = d & 32'hC0;
            default: ;
        endcase
    endtask

    task automatic model_step();
        if (m_phase != 2) return;
        if ((m_ctrl & 32'h80) == 0) m_c64 = (m_c64 + 1) % 65536;
        if ((m_ctrl & 32'h40) == 0) m_reu = (m_reu + 1) % REU_SIZE;
        m_len = (m_len == 1) ? 1 : (m_len + 65535) % 65536;
    endtask

    task automatic model_done(bit verr);
        if (m_phase != 2) return;
        m_status |= verr ? 32'h20 : 32'h40;
        m_cmd &= 32'h7F;
        if ((m_cmd & 32'h20) != 0) begin m_c64 = s_c64; m_reu = s_reu; m_len = s_len; end
        m_phase = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_dq"},    bus.d_q,       m_dq);
        check({tag, "_c64"},   bus.c64_addr,  m_c64);
        check({tag, "_reu"},   bus.reu_addr,  m_reu);
        check({tag, "_len"},   bus.xfer_len,  m_len);
        check({tag, "_type"},  bus.xfer_type, m_cmd & 3);
        check({tag, "_busy"},  bus.dma_busy,  m_phase == 2);
        check({tag, "_start"}, bus.dma_start, m_start);
        check({tag, "_irq"},   bus.irq,       m_status >> 7);
    endtask

    task automatic clear_inputs();
        bus.write_strobe = 0; bus.read_strobe = 0; bus.ff00_write = 0;
        bus.dma_step = 0; bus.dma_done = 0; bus.verify_err = 0;
    endtask

    task automatic do_cycle(input string tag, bit wr, bit rd, bit ff, bit st, bit dn, bit ve,
                            logic [4:0] idx, logic [7:0] d);
        bus.a = idx; bus.d_d = d; bus.write_strobe = wr; bus.read_strobe = rd;
        bus.ff00_write = ff; bus.dma_step = st; bus.dma_done = dn; bus.verify_err = ve;
        m_start = 0;
        if (rd) begin
            m_dq = model_read(idx);
            if (idx == 0) m_status &= 32'h1F;
        end
        if (wr) model_write(idx, d);
        if (ff && m_phase == 1) begin m_phase = 2; m_start = 1; end
        if (st) model_step();
        if (dn) model_done(ve);
        if ((m_mask & 32'h80) != 0 && (m_mask & m_status & 32'h60) != 0) m_status |= 32'h80;
        @(posedge clk); #1;
        clear_inputs();
        check_outputs(tag);
    endtask

    task automatic wr(logic [4:0] idx, logic [7:0] d); do_cycle("wr", 1, 0, 0, 0, 0, 0, idx, d); endtask
    task automatic rd(logic [4:0] idx); do_cycle("rd", 0, 1, 0, 0, 0, 0, idx, 8'h00); endtask
    task automatic step(); do_cycle("step", 0, 0, 0, 1, 0, 0, 5'd0, 8'h00); endtask
    task automatic done(bit ve); do_cycle("done", 0, 0, 0, 0, 1, ve, 5'd0, 8'h00); endtask
    task automatic ff00(); do_cycle("ff00", 0, 0, 1, 0, 0, 0, 5'd0, 8'h00); endtask
    task automatic idle(); do_cycle("idle", 0, 0, 0, 0, 0, 0, 5'd0, 8'h00); endtask

    task automatic do_reset();
        reset = 1; clear_inputs();
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        check_outputs("rst");
    endtask

    initial begin
        int unsigned k;
        logic [4:0]  idx;
        reset = 1; bus.a = 0; bus.d_d = 0; clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_dq_ff", bus.d_q, 8'hFF);
        for (int i = 0; i <= 12; i++) rd(5'(i));
        rd(5'd1);
        check("rst_cmd_5c", bus.d_q, 8'h5C);

        // Immediate launch with FF00 decoding disabled.
        wr(5'd1, 8'h90);
        check("imm_start", bus.dma_start, 1'b1);
        check("imm_busy", bus.dma_busy, 1'b1);
        rd(5'd1);
        check("imm_cmd_dc", bus.d_q, 8'hDC);
        wr(5'd2, 8'h55);
        done(0);

        // Armed launch waits for the $FF00 write.
        do_reset();
        wr(5'd1, 8'h80);
        repeat (10) idle();
        ff00();
        check("ff00_start", bus.dma_start, 1'b1);
        idle();
        done(0);

        // C64 address wrap with REU address fixed.
        do_reset();
        wr(5'd2, 8'hFF); wr(5'd3, 8'hFF); wr(5'd10, 8'h40); wr(5'd7, 8'h10); wr(5'd8, 8'h00);
        wr(5'd1, 8'h90);
        step(); step();
        check("wrap_c64", bus.c64_addr, 16'h0001);
        check("wrap_len", bus.xfer_len, 16'h000E);
        do_cycle("stepdone", 0, 0, 0, 1, 1, 0, 5'd0, 8'h00);

        // Autoload restores the programmed transfer.
        do_reset();
        wr(5'd2, 8'h00); wr(5'd3, 8'h10); wr(5'd4, 8'h00); wr(5'd5, 8'h00); wr(5'd6, 8'h02);
        wr(5'd7, 8'h04); wr(5'd8, 8'h00);
        wr(5'd1, 8'hB0);
        repeat (4) step();
        check("al_len_floor", bus.xfer_len, 16'h0001);
        done(0);
        check("al_c64", bus.c64_addr, 16'h1000);
        check("al_reu", bus.reu_addr, 24'h02_0000);
        check("al_len", bus.xfer_len, 16'h0004);
        rd(5'd0);
        check("al_status", bus.d_q, 8'h50);

        // Verify error raises the interrupt; status read clears it.
        do_reset();
        wr(5'd9, 8'hA0);
        wr(5'd1, 8'h90);
        done(1);
        check("irq_set", bus.irq, 1'b1);
        rd(5'd0);
        check("irq_status", bus.d_q, 8'hB0);
        rd(5'd0);
        check("irq_cleared", bus.d_q, 8'h10);
        check("irq_low", bus.irq, 1'b0);

        // Bank width and REU address wrap.
        do_reset();
        wr(5'd6, 8'hFF);
        rd(5'd6);
        check("bank_rd", bus.d_q, 8'hFF);
        wr(5'd4, 8'hFF); wr(5'd5, 8'hFF);
        wr(5'd1, 8'h90);
        step();
`ifndef REU_16M_EN
        check("reu_wrap", bus.reu_addr, 24'h00_0000);
`endif
        wr(5'd9, 8'h00);
        do_cycle("rddone", 0, 1, 0, 0, 1, 1, 5'd0, 8'h00);
        do_cycle("rddone2", 0, 1, 0, 0, 0, 0, 5'd0, 8'h00);

        // Random traffic, including mid-transfer reset.
        for (int i = 0; i < 800; i++) begin
            k = $urandom_range(0, 19);
            if ($urandom_range(0, 3) == 0) idx = 5'($urandom_range(0, 31));
            else idx = 5'($urandom_range(1, 10));
            if (k < 6) wr(idx, 8'($urandom_range(0, 255)));
            else if (k < 9) rd(idx);
            else if (k < 12) step();
            else if (k < 14) done(1'($urandom_range(0, 1)));
            else if (k < 15) ff00();
            else if (k < 16) do_cycle("stepdone", 0, 0, 0, 1, 1, 1'($urandom_range(0, 1)), 5'd0, 8'h00);
            else if (k < 17) do_cycle("rddone", 0, 1, 0, 0, 1, 1'($urandom_range(0, 1)), 5'd0, 8'h00);
            else if (k < 18 && $urandom_range(0, 7) == 0) do_reset();
            else idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
